// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] res;
        for (int i = 0; i < BE_W; i++)
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: byte-masked synchronous write, synchronous read.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= be_merge(mem[idx], wdata, be);
        rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one response each.
// Define MEM_ERR_EN to flag out-of-range/misaligned requests with rsp_err instead of aliasing.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic              lat_err;
    logic [IDX_W-1:0]  lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              rd_sel;
    logic [31:0]       offs;
    logic              req_bad;
    logic              access;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign offs = req_addr - BASE_ADDR;

`ifdef MEM_ERR_EN
    assign req_bad = (offs >= 32'(4 * DEPTH_WORDS)) || (req_addr[1:0] != 2'b00);
`else
    // Upper offset bits and the byte lane are deliberately dropped (aliasing).
    assign req_bad = 1'b0 & (^{offs[31:IDX_W+2], offs[1:0]});
`endif

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign access    = (state == WAIT) && (cnt == 4'd0);
    assign ram_we    = access && lat_we && !lat_err;
    // RAM output is live only for successful loads; everything else reads as 0.
    assign rsp_rdata = rd_sel ? ram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rd_sel    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_we    <= req_we;
                    lat_err   <= req_bad;
                    lat_idx   <= offs[IDX_W+1:2];
                    lat_wdata <= req_wdata;
                    lat_be    <= req_be;
                    cnt       <= 4'(WAIT_CYCLES);
                    state     <= WAIT;
                end
                WAIT: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_err;
                    rd_sel    <= !lat_we && !lat_err;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rd_sel    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (lat_be),
        .idx   (lat_idx),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3), vector table plus corner sequences.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC), .BASE_ADDR(32'h0000_1000)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g]), .busy(busy[g])
        );
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request, wait for the accept edge, queue its expected response.
    task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr);
        int t = 0;
        exp_t e;
        @(negedge clk);
        req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
        req_valid[k] = 1'b1;
        while (!req_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("accept_ready%0d", k), 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        e.rdata = erd; e.err = eerr;
        sb.push_back(e);
        #1 req_valid[k] = 1'b0;
    endtask

    task automatic pop_cmp(input int k, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata[k], e.rdata);
            chk({tag, "_err"}, 32'(rsp_err[k]), 32'(e.err));
        end
    endtask

    // Wait for the response (rsp_ready assumed 1), check latency, data and return to IDLE.
    task automatic collect(input int k, input string tag, input int lat);
        int n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!rsp_valid[k] && n < 50);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        pop_cmp(k, tag);
        @(posedge clk);
        #1;
        chk({tag, "_vld_clr"}, 32'(rsp_valid[k]), 32'd0);
        chk({tag, "_idle"}, 32'({busy[k], req_ready[k]}), 32'b01);
    endtask

    vec_t vecs[15];

    initial begin
        int n;
        int bcnt;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h1010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h1014, 32'h11223344, 4'hF, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h1014, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h1014, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h1014, 32'h01020304, 4'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h1014, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h1018, 32'h00000000, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 32'h1018, 32'hFFFFFFFF, 4'hA, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h1018, 32'h0,        4'h0, 32'hFF00FF00, 1'b0};
        vecs[10] = '{1'b1, 32'h13FC, 32'h12345678, 4'hF, 32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0, 1'b0};
`ifdef MEM_ERR_EN
        vecs[12] = '{1'b1, 32'h1400, 32'h99999999, 4'hF, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 32'h1002, 32'h0,        4'h0, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h77777777, 1'b0};
`else
        vecs[12] = '{1'b1, 32'h1400, 32'h99999999, 4'hF, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h1002, 32'h0,        4'h0, 32'h99999999, 1'b0};
        vecs[14] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h99999999, 1'b0};
`endif

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_outs%0d", k),
                32'({rsp_valid[k], rsp_err[k], busy[k], req_ready[k]}), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rsp_rdata[k], 32'h0);
        end
        @(negedge clk) rst = 1'b0;
        #1 chk("rdy_after_rst", 32'({req_ready[0], req_ready[1], req_ready[2]}), 32'b111);

        // Vector table on the WAIT_CYCLES=1 instance
        for (int i = 0; i < 15; i++) begin
            issue(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdata, vecs[i].err);
            collect(0, $sformatf("vec%0d", i), 2);
        end
        issue(0, 1'b0, 32'h13FC, 32'h0, 4'h0, 32'h12345678, 1'b0);
        collect(0, "last_word", 2);

        // Backpressure with a competing store held on the request channel
        @(negedge clk) rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h1010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!rsp_valid[0] && n < 50);
        chk("bp_lat", 32'(n), 32'd2);
        held = rsp_rdata[0];
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h1020; req_wdata[0] = 32'h55555555; req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", c), 32'({rsp_valid[0], req_ready[0]}), 32'b10);
            chk($sformatf("bp_data%0d", c), rsp_rdata[0], held);
        end
        pop_cmp(0, "bp");
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 chk("bp_release", 32'({rsp_valid[0], req_ready[0]}), 32'b01);
        @(posedge clk);
        sb.push_back('{32'h0, 1'b0});
        #1 req_valid[0] = 1'b0;
        chk("held_accepted", 32'(busy[0]), 32'd1);
        collect(0, "held", 2);
        issue(0, 1'b0, 32'h1020, 32'h0, 4'h0, 32'h55555555, 1'b0);
        collect(0, "held_rd", 2);

        // WAIT_CYCLES=0 instance: latency 1, busy for exactly two cycles
        issue(1, 1'b1, 32'h1040, 32'hAAAA5555, 4'hF, 32'h0, 1'b0);
        collect(1, "w0_st", 1);
        issue(1, 1'b0, 32'h1040, 32'h0, 4'h0, 32'hAAAA5555, 1'b0);
        bcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy[1]) bcnt++;
            if (rsp_valid[1]) pop_cmp(1, "w0_ld");
        end
        chk("w0_busy_cycles", 32'(bcnt), 32'd2);

        // WAIT_CYCLES=3 instance: reset during WAIT discards the store
        issue(2, 1'b1, 32'h1030, 32'h12345678, 4'hF, 32'h0, 1'b0);
        collect(2, "w3_st", 4);
        issue(2, 1'b1, 32'h1030, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1 chk("midwait_rst", 32'({rsp_valid[2], req_ready[2], busy[2]}), 32'd0);
        @(negedge clk) rst = 1'b0;
        issue(2, 1'b0, 32'h1030, 32'h0, 4'h0, 32'h12345678, 1'b0);
        collect(2, "w3_after_rst", 4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's memory-stage load/store requests over a valid/ready request channel and a valid/ready response channel.
- Sits behind the memory stage. It owns the word-addressed data RAM and inserts a programmable number of wait states.
- Every request, read or write, produces exactly one response.

Parameters:
- DEPTH_WORDS, 256: RAM depth in 32-bit words; must be a power of 2, at least 4.
- WAIT_CYCLES, 1: extra cycles between request accept and RAM access; range 0..15.
- BASE_ADDR, 32'h0000_1000: byte address of word 0.

Ports:
- clk  in  1  : clock, rising edge.
- rst  in  1  : asynchronous reset, active-high.
- req_valid  in  1  : request present.
- req_ready  out  1  : responder can accept a request.
- req_we  in  1  : 1 = store, 0 = load.
- req_addr  in  32  : byte address.
- req_wdata  in  32  : store data.
- req_be  in  4  : store byte enables; bit i enables byte i, i.e. wdata[8i+7:8i].
- rsp_valid  out  1  : response present.
- rsp_ready  in  1  : core accepts the response.
- rsp_rdata  out  32  : load data; 0 for stores.
- rsp_err  out  1  : access error; constant 0 unless MEM_ERR_EN is defined.
- busy  out  1  : high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - req_ready is forced to 0 while rst is high.
  - Wait counter is cleared.
  - RAM contents are not reset.
- FSM IDLE:
  - req_ready=1.
  - On an edge with req_valid && req_ready: latch we/addr/wdata/be, load cnt=WAIT_CYCLES, go to WAIT.
- FSM WAIT:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access on this edge and go to RESP.
    - Store: write enabled bytes only; rsp_rdata<=0.
    - Load: rsp_rdata<=full word; req_be is ignored.
    - Set rsp_valid<=1.
- FSM RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until an edge with rsp_ready=1; on that edge clear rsp_valid and go to IDLE.
- Latency: rsp_valid first rises WAIT_CYCLES+1 edges after the accept edge.
- Throughput: minimum WAIT_CYCLES+3 cycles per transaction. There is no back-to-back acceptance; req_ready is combinational from state only.
- Word index: idx = (req_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits. Out-of-range addresses alias (wrap modulo the RAM size).
- Misaligned address (addr[1:0]!=0): the low two bits are ignored and the word is accessed.
- req_be==0 store: no RAM change; still acknowledged.
- A store followed by a load to the same word returns the new data; no RAM bypass is needed because the accesses are serialised.
- Inputs are ignored outside IDLE, even if req_valid is asserted.
- Reset mid-operation:
  - A store still in WAIT is discarded; the RAM is unchanged.
  - A pending response in RESP is dropped.

Optional Feature:
MEM_ERR_EN:
- Defined:
  - Out-of-range ((req_addr - BASE_ADDR) >= 4*DEPTH_WORDS, unsigned) or misaligned (addr[1:0]!=0) requests complete with rsp_err=1 and rsp_rdata=0. A store is not performed.
  - Timing is identical to a normal access.
  - rsp_err clears together with rsp_valid.
- Undefined: rsp_err is tied to 0; aliasing and low-bit dropping apply as described above.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - localparams WORD_W=32, BE_W=4;
  - helper function for byte-masked merge (old word, new word, be).
- Sub-module dmem_ram holds the word array:
  - synchronous write with byte enables;
  - synchronous read;
  - ports clk, we, be, idx, wdata, rdata.
- The FSM, counter and error check stay in dmem_responder.

Test Plan:
- Basic store/load, WAIT_CYCLES=1:
  - Store 0xDEADBEEF to 0x1010, be=4'hF, accepted at edge 0 -> rsp_valid after edge 2, rsp_rdata=0.
  - Load 0x1010 -> rsp_rdata=0xDEADBEEF.
- Byte enables:
  - Store 0x11223344 full, then store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD.
  - Store with be=0 -> word unchanged, response still given.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a held req_valid is not accepted until after the rsp_ready handshake.
- Reset mid-WAIT, WAIT_CYCLES=3:
  - Store 0xCAFEF00D over 0x12345678 and pulse rst during WAIT -> rsp_valid=0 and req_ready=0 immediately.
  - After reset, load returns 0x12345678.
- WAIT_CYCLES=0: rsp_valid after edge 1 following accept; busy high for exactly 2 cycles when rsp_ready is held at 1.
- Address boundaries, DEPTH_WORDS=256:
  - Without MEM_ERR_EN: store to 0x1400 aliases 0x1000; load 0x1002 returns the word at 0x1000.
  - With MEM_ERR_EN: both requests give rsp_err=1, rsp_rdata=0, and the word at 0x1000 is unchanged.
